mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction cache (line refills) and the data cache (line refills and line write-backs).
- Sits between `instruction_cache`/`data_cache` and `main_memory` inside `top`.
- Each request is a fixed-length burst of BURST_LEN words.
- Arbitration is round-robin; a granted burst runs to completion before the next grant.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache refills and
// D-cache refills/write-backs; each grant runs a fixed BURST_LEN-word burst to completion.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int BURST_LEN  = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_req,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  output logic [LEN-1:0]        icache_rdata,
  output logic                  icache_rvalid,
  output logic                  icache_done,
  input  logic                  dcache_req,
  input  logic                  dcache_we,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic [LEN-1:0]        dcache_wdata,
  output logic                  dcache_wnext,
  output logic [LEN-1:0]        dcache_rdata,
  output logic                  dcache_rvalid,
  output logic                  dcache_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LEN-1:0]        mem_wdata,
  input  logic [LEN-1:0]        mem_rdata,
  output logic                  busy,
  output logic [1:0]            grant
);

  localparam int IDX_W  = $clog2(BURST_LEN);
  localparam int BASE_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  typedef enum logic [1:0] {GNT_NONE = 2'b00, GNT_I = 2'b01, GNT_D = 2'b10} grant_e;

  state_e              state_q, state_d;
  grant_e              grant_q, grant_d;
  grant_e              last_grant_q, last_grant_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic                we_q, we_d;
  logic                mem_en_q, mem_en_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W:0]      ret_cnt_q, ret_cnt_d;
  logic [MEM_LAT-1:0]  vld_q, vld_d;
  logic                icache_done_q, icache_done_d;
  logic                dcache_done_q, dcache_done_d;

  grant_e              pick;
  logic                burst_end;
  logic                rd_ret;
  logic [IDX_W:0]      ret_total;

  // The oldest stage of the valid pipeline marks the word arriving on mem_rdata now.
  assign rd_ret    = vld_q[MEM_LAT-1];
  assign ret_total = ret_cnt_q + (IDX_W+1)'(rd_ret);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    base_d        = base_q;
    we_d          = we_q;
    idx_d         = idx_q;
    ret_cnt_d     = ret_total;
    mem_en_d      = 1'b0;
    pick          = GNT_NONE;
    burst_end     = 1'b0;
    vld_d         = vld_q << 1;
    vld_d[0]      = mem_en_q & ~we_q;

    case (state_q)
      IDLE: begin
        if (icache_req || dcache_req) begin
          if (icache_req && dcache_req)
            pick = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
          else
            pick = dcache_req ? GNT_D : GNT_I;
          grant_d      = pick;
          last_grant_d = pick;
          base_d       = (pick == GNT_D) ? dcache_addr[ADDR_WIDTH-1:IDX_W]
                                         : icache_addr[ADDR_WIDTH-1:IDX_W];
          we_d         = (pick == GNT_D) && dcache_we;
          idx_d        = '0;
          ret_cnt_d    = '0;
          mem_en_d     = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (idx_q == IDX_W'(BURST_LEN - 1)) begin
          // Writes have nothing to wait for; reads must collect every return first.
          if (we_q) begin
            state_d   = DONE;
            burst_end = 1'b1;
          end else begin
            state_d   = DRAIN;
          end
        end else begin
          idx_d    = idx_q + 1'b1;
          mem_en_d = 1'b1;
        end
      end
      DRAIN: begin
        if (ret_total == (IDX_W+1)'(BURST_LEN)) begin
          state_d   = DONE;
          burst_end = 1'b1;
        end
      end
      DONE: begin
        grant_d = GNT_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    icache_done_d = burst_end && (grant_q == GNT_I);
    dcache_done_d = burst_end && (grant_q == GNT_D);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= GNT_NONE;
      last_grant_q  <= GNT_I;
      base_q        <= '0;
      we_q          <= 1'b0;
      mem_en_q      <= 1'b0;
      idx_q         <= '0;
      ret_cnt_q     <= '0;
      vld_q         <= '0;
      icache_done_q <= 1'b0;
      dcache_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      base_q        <= base_d;
      we_q          <= we_d;
      mem_en_q      <= mem_en_d;
      idx_q         <= idx_d;
      ret_cnt_q     <= ret_cnt_d;
      vld_q         <= vld_d;
      icache_done_q <= icache_done_d;
      dcache_done_q <= dcache_done_d;
    end
  end

  assign mem_en        = mem_en_q;
  assign mem_we        = mem_en_q & we_q;
  assign mem_addr      = mem_en_q ? {base_q, idx_q} : '0;
  assign mem_wdata     = (mem_en_q & we_q) ? dcache_wdata : '0;
  assign dcache_wnext  = mem_en_q & we_q;

  assign icache_rvalid = rd_ret && (grant_q == GNT_I);
  assign dcache_rvalid = rd_ret && (grant_q == GNT_D);
  assign icache_rdata  = icache_rvalid ? mem_rdata : '0;
  assign dcache_rdata  = dcache_rvalid ? mem_rdata : '0;
  assign icache_done   = icache_done_q;
  assign dcache_done   = dcache_done_q;

  assign busy          = (state_q != IDLE);
  assign grant         = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) with memory models,
// checked cycle by cycle against burst timing and round-robin rules computed here.
module tb_mem_arbiter;

  localparam int AW   = 17;
  localparam int LEN  = 32;
  localparam int BL   = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           icache_req   [2];
  logic [AW-1:0]  icache_addr  [2];
  wire  [LEN-1:0] icache_rdata [2];
  wire            icache_rvalid[2];
  wire            icache_done  [2];
  logic           dcache_req   [2];
  logic           dcache_we    [2];
  logic [AW-1:0]  dcache_addr  [2];
  logic [LEN-1:0] dcache_wdata [2];
  wire            dcache_wnext [2];
  wire  [LEN-1:0] dcache_rdata [2];
  wire            dcache_rvalid[2];
  wire            dcache_done  [2];
  wire            mem_en       [2];
  wire            mem_we       [2];
  wire  [AW-1:0]  mem_addr     [2];
  wire  [LEN-1:0] mem_wdata    [2];
  wire  [LEN-1:0] mem_rdata    [2];
  wire            busy         [2];
  wire  [1:0]     grant        [2];

  mem_arbiter #(.ADDR_WIDTH(AW), .LEN(LEN), .BURST_LEN(BL), .MEM_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .icache_req(icache_req[0]), .icache_addr(icache_addr[0]), .icache_rdata(icache_rdata[0]),
    .icache_rvalid(icache_rvalid[0]), .icache_done(icache_done[0]),
    .dcache_req(dcache_req[0]), .dcache_we(dcache_we[0]), .dcache_addr(dcache_addr[0]),
    .dcache_wdata(dcache_wdata[0]), .dcache_wnext(dcache_wnext[0]), .dcache_rdata(dcache_rdata[0]),
    .dcache_rvalid(dcache_rvalid[0]), .dcache_done(dcache_done[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .grant(grant[0])
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .LEN(LEN), .BURST_LEN(BL), .MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .icache_req(icache_req[1]), .icache_addr(icache_addr[1]), .icache_rdata(icache_rdata[1]),
    .icache_rvalid(icache_rvalid[1]), .icache_done(icache_done[1]),
    .dcache_req(dcache_req[1]), .dcache_we(dcache_we[1]), .dcache_addr(dcache_addr[1]),
    .dcache_wdata(dcache_wdata[1]), .dcache_wnext(dcache_wnext[1]), .dcache_rdata(dcache_rdata[1]),
    .dcache_rvalid(dcache_rvalid[1]), .dcache_done(dcache_done[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .grant(grant[1])
  );

  // Memory models: unwritten words read back a per-address pattern; reads return after the
  // instance's latency, and idle cycles drive a junk value so ungated read data shows up.
  logic [LEN-1:0] mem     [2][2**AW];
  logic           written [2][2**AW];
  logic [LEN-1:0] rpipe   [2][3];
  logic           pl_en = 1'b0;
  int             pl_k;
  logic [AW-1:0]  pl_addr;
  logic [LEN-1:0] pl_data;

  function automatic logic [LEN-1:0] init_val(input int k, input logic [AW-1:0] a);
    return {8'(k + 1), 7'h00, a};
  endfunction

  function automatic logic [LEN-1:0] mem_read(input int k, input logic [AW-1:0] a);
    return (written[k][a] === 1'b1) ? mem[k][a] : init_val(k, a);
  endfunction

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_k][pl_addr]     <= pl_data;
      written[pl_k][pl_addr] <= 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k] && mem_we[k]) begin
        mem[k][mem_addr[k]]     <= mem_wdata[k];
        written[k][mem_addr[k]] <= 1'b1;
      end
      rpipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mem_read(k, mem_addr[k]) : 32'hBADC_0DE0;
      rpipe[k][1] <= rpipe[k][0];
      rpipe[k][2] <= rpipe[k][1];
    end
  end

  assign mem_rdata[0] = rpipe[0][LAT0-1];
  assign mem_rdata[1] = rpipe[1][LAT1-1];

  int             n_checks = 0;
  int             n_errors = 0;
  bit             last_d [2];
  logic [LEN-1:0] wr_words [2][BL];
  int             late_c = 0;
  logic [AW-1:0]  late_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input int k, input logic [AW-1:0] a, input logic [LEN-1:0] d);
    pl_k = k; pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_quiet(input int k);
    check("q_busy", busy[k], 0);
    check("q_grant", grant[k], 0);
    check("q_mem_en", mem_en[k], 0);
    check("q_mem_we", mem_we[k], 0);
    check("q_mem_addr", mem_addr[k], 0);
    check("q_mem_wdata", mem_wdata[k], 0);
    check("q_wnext", dcache_wnext[k], 0);
    check("q_i_rvalid", icache_rvalid[k], 0);
    check("q_i_rdata", icache_rdata[k], 0);
    check("q_i_done", icache_done[k], 0);
    check("q_d_rvalid", dcache_rvalid[k], 0);
    check("q_d_rdata", dcache_rdata[k], 0);
    check("q_d_done", dcache_done[k], 0);
  endtask

  task automatic setup(input int k, input bit is_d, input bit we, input logic [AW-1:0] addr);
    if (is_d) begin
      dcache_req[k]  = 1'b1;
      dcache_we[k]   = we;
      dcache_addr[k] = addr;
      for (int i = 0; i < BL; i++) wr_words[k][i] = $urandom();
      dcache_wdata[k] = wr_words[k][0];
    end else begin
      icache_req[k]  = 1'b1;
      icache_addr[k] = addr;
    end
  endtask

  // Called at the falling edge of the IDLE cycle in which the granted request is sampled
  // (cycle 0); checks every output through the done cycle from burst timing alone.
  task automatic check_burst(input int k, input bit is_d);
    bit             we   = is_d && dcache_we[k];
    logic [AW-1:0]  addr = is_d ? dcache_addr[k] : icache_addr[k];
    logic [AW-1:0]  base = addr & ~AW'(BL - 1);
    int             lat  = (k == 0) ? LAT0 : LAT1;
    int             n    = we ? BL + 1 : BL + lat + 1;
    int             widx = 0;
    bit             wn_prev = 1'b0;
    logic [LEN-1:0] exp_rd [BL];
    bit             en, rv;
    for (int i = 0; i < BL; i++) exp_rd[i] = mem_read(k, base + AW'(i));
    check("c0_busy", busy[k], 0);
    check("c0_mem_en", mem_en[k], 0);
    check("c0_grant", grant[k], 0);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (is_d && wn_prev && widx < BL - 1) begin
        widx++;
        dcache_wdata[k] = wr_words[k][widx];
      end
      @(negedge clk);
      en = (c <= BL);
      rv = !we && (c > lat) && (c <= BL + lat);
      check("mem_en", mem_en[k], en);
      if (en) check("mem_addr", mem_addr[k], base + AW'(c - 1));
      check("mem_we", mem_we[k], en && we);
      if (en && we) check("mem_wdata", mem_wdata[k], wr_words[k][c-1]);
      check("wnext", dcache_wnext[k], en && we);
      check("busy", busy[k], 1);
      if (c < n) check("grant", grant[k], is_d ? 2'b10 : 2'b01);
      check("rvalid", is_d ? dcache_rvalid[k] : icache_rvalid[k], rv);
      if (rv) check("rdata", is_d ? dcache_rdata[k] : icache_rdata[k], exp_rd[c-1-lat]);
      check("done", is_d ? dcache_done[k] : icache_done[k], c == n);
      check("other_rvalid", is_d ? icache_rvalid[k] : dcache_rvalid[k], 0);
      check("other_rdata", is_d ? icache_rdata[k] : dcache_rdata[k], 0);
      check("other_done", is_d ? icache_done[k] : dcache_done[k], 0);
      wn_prev = dcache_wnext[k];
      if (c == late_c) begin
        icache_req[k]  = 1'b1;
        icache_addr[k] = late_addr;
      end
      if (c == n) begin
        if (is_d) dcache_req[k] = 1'b0;
        else      icache_req[k] = 1'b0;
      end
    end
    if (we)
      for (int i = 0; i < BL; i++) check("wb_mem", mem_read(k, base + AW'(i)), wr_words[k][i]);
  endtask

  // One arbitration round: tie goes to whoever was not granted last, the loser follows.
  task automatic do_round(input int k, input bit want_i, input bit want_d, input bit d_we);
    bit win_d;
    step();
    if (want_i) setup(k, 1'b0, 1'b0, AW'($urandom_range(0, 2**AW - 1)));
    if (want_d) setup(k, 1'b1, d_we, AW'($urandom_range(0, 2**AW - 1)));
    win_d = (want_i && want_d) ? !last_d[k] : want_d;
    last_d[k] = win_d;
    check_burst(k, win_d);
    if (want_i && want_d) begin
      step();
      last_d[k] = !win_d;
      check_burst(k, !win_d);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      icache_req[k] = 1'b0; icache_addr[k] = '0;
      dcache_req[k] = 1'b0; dcache_we[k] = 1'b0; dcache_addr[k] = '0; dcache_wdata[k] = '0;
      last_d[k] = 1'b0;
    end
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet(0);
    check_quiet(1);
    for (int i = 0; i < 4; i++) preload(0, AW'(32'h40 + i), 32'hA0 + i);
    rst = 1'b1;

    // Ties straight after reset: D-cache first, then alternating.
    for (int t = 0; t < 4; t++) do_round(0, 1'b1, 1'b1, t[0]);

    // I-cache refill of the preloaded line at 0x40.
    step();
    setup(0, 1'b0, 1'b0, AW'(32'h40));
    last_d[0] = 1'b0;
    check_burst(0, 1'b0);

    // D-cache write-back to 0x107; low address bits are ignored.
    step();
    setup(0, 1'b1, 1'b1, AW'(32'h107));
    for (int i = 0; i < BL; i++) wr_words[0][i] = 32'hD0 + i;
    dcache_wdata[0] = wr_words[0][0];
    last_d[0] = 1'b1;
    check_burst(0, 1'b1);

    // Longer memory latency: I refill, D refill, D write-back.
    do_round(1, 1'b1, 1'b0, 1'b0);
    do_round(1, 1'b0, 1'b1, 1'b0);
    do_round(1, 1'b0, 1'b1, 1'b1);

    // I-cache request arriving during a D-cache burst waits for the next IDLE.
    step();
    setup(0, 1'b1, 1'b1, AW'($urandom_range(0, 2**AW - 1)));
    last_d[0] = 1'b1;
    late_c    = 2;
    late_addr = AW'($urandom_range(0, 2**AW - 1));
    check_burst(0, 1'b1);
    late_c = 0;
    step();
    last_d[0] = 1'b0;
    check_burst(0, 1'b0);

    // Reset during ISSUE word 2 abandons the burst with no done pulse.
    step();
    setup(0, 1'b0, 1'b0, AW'($urandom_range(0, 2**AW - 1)));
    for (int c = 1; c <= 3; c++) step();
    check("pre_rst_mem_en", mem_en[0], 1);
    rst = 1'b0;
    #1;
    check_quiet(0);
    check_quiet(1);
    icache_req[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("rst_i_done", icache_done[0], 0);
      check("rst_i_rvalid", icache_rvalid[0], 0);
      check("rst_busy", busy[0], 0);
    end
    rst = 1'b1;
    last_d[0] = 1'b0;
    last_d[1] = 1'b0;
    do_round(0, 1'b1, 1'b0, 1'b0);
    do_round(0, 1'b1, 1'b1, 1'b0);

    // Randomized rounds on both instances.
    for (int r = 0; r < 40; r++) begin
      int k = int'($urandom_range(0, 1));
      int p = int'($urandom_range(0, 2));
      do_round(k, p != 1, p != 0, 1'($urandom_range(0, 1)));
    end

    step();
    check_quiet(0);
    check_quiet(1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
